// File: rtl/johnson_count_ctrl.sv
// Run controller for the Johnson counter: Wishbone register file, WB/LA start
// arbitration and enable/clear/load sequencing for an exact number of steps.
module johnson_count_ctrl #(
  parameter int unsigned BITS   = 32,
  parameter int unsigned STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              la_start,
  input  logic [STEP_W-1:0] la_steps,
  output logic              la_grant,
  input  logic [BITS-1:0]   cnt_value,
  output logic              cnt_en,
  output logic              cnt_clr,
  output logic              cnt_load,
  output logic [BITS-1:0]   cnt_load_val,
  output logic              irq_done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_nx;
  logic [STEP_W-1:0] steps_q, remaining_q, start_steps;
  logic              done_q, irq_en_q, owner_q, ack_q;
  logic [31:0]       dat_q, rdata;
  logic              clr_q, load_q;
  logic [BITS-1:0]   load_val_q;

  logic       wb_valid, wb_wr, wb_rd, ctrl_wr;
  logic [1:0] reg_sel;
  logic       cmd_start, cmd_stop, cmd_clear, wr_value, status_w1c;
  logic       wb_accept, la_accept, start_accept, busy;
  logic       unused_ok;

  assign wb_valid   = wbs_cyc_i & wbs_stb_i & ~ack_q;
  assign wb_wr      = wb_valid & wbs_we_i;
  assign wb_rd      = wb_valid & ~wbs_we_i;
  assign reg_sel    = wbs_adr_i[3:2];
  assign ctrl_wr    = wb_wr && (reg_sel == 2'd0) && wbs_sel_i[0];
  assign cmd_start  = ctrl_wr & wbs_dat_i[0];
  assign cmd_stop   = ctrl_wr & wbs_dat_i[1];
  assign cmd_clear  = ctrl_wr & wbs_dat_i[2];
  assign wr_value   = wb_wr && (reg_sel == 2'd3);
  assign status_w1c = wb_wr && (reg_sel == 2'd2) && wbs_sel_i[0] && wbs_dat_i[1];

  assign busy         = (state != IDLE);
  assign wb_accept    = cmd_start & ~busy;
  // Wishbone has priority; a simultaneous LA request is dropped, not queued.
  assign la_accept    = la_start & ~busy & ~cmd_start;
  assign start_accept = wb_accept | la_accept;
  assign start_steps  = wb_accept ? steps_q : la_steps;

  assign unused_ok = ^{wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_sel_i[3:1]};

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start_accept) state_nx = (start_steps == '0) ? DONE : RUN;
      RUN: begin
        if (cmd_stop) state_nx = IDLE;
        else if (remaining_q == STEP_W'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata[3] = irq_en_q;
      2'd1: rdata[STEP_W-1:0] = steps_q;
      2'd2: begin
        rdata[0]     = busy;
        rdata[1]     = done_q;
        rdata[2]     = owner_q;
        rdata[31:16] = 16'(remaining_q);
      end
      default: rdata = 32'(cnt_value);
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      steps_q     <= '0;
      remaining_q <= '0;
      done_q      <= 1'b0;
      irq_en_q    <= 1'b0;
      owner_q     <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      clr_q       <= 1'b0;
      load_q      <= 1'b0;
      load_val_q  <= '0;
    end else begin
      ack_q <= wb_valid;
      dat_q <= wb_rd ? rdata : '0;

      if (ctrl_wr) irq_en_q <= wbs_dat_i[3];
      if (wb_wr && (reg_sel == 2'd1)) begin
        for (int unsigned b = 0; b < STEP_W; b++)
          if (wbs_sel_i[b/8]) steps_q[b] <= wbs_dat_i[b];
      end

      // Remaining also decrements on the stop edge, so it always equals
      // the steps still owed after the enable cycles already issued.
      if (start_accept)       remaining_q <= start_steps;
      else if (state == RUN)  remaining_q <= remaining_q - STEP_W'(1);

      if (wb_accept)      owner_q <= 1'b0;
      else if (la_accept) owner_q <= 1'b1;

      if (state == DONE)   done_q <= 1'b1;
      else if (status_w1c) done_q <= 1'b0;

      clr_q  <= cmd_clear & ~busy;
      load_q <= wr_value & ~busy;
      if (wr_value && !busy) load_val_q <= BITS'(wbs_dat_i);
    end
  end

  assign wbs_ack_o    = ack_q;
  assign wbs_dat_o    = dat_q;
  assign la_grant     = la_accept & reset_n;
  assign cnt_en       = (state == RUN);
  assign cnt_clr      = clr_q;
  assign cnt_load     = load_q;
  assign cnt_load_val = load_val_q;
  assign irq_done     = done_q & irq_en_q;

endmodule

// File: doc/johnson_count_ctrl.md
# johnson_count_ctrl

Run controller for the user-project Johnson counter. It exposes a Wishbone register file and accepts start requests from both Wishbone and the logic analyzer, arbitrating between them. It sequences the counter's enable, clear and load controls to run an exact number of steps, then raises a done interrupt. It sits between the Wishbone/LA ports of the user project wrapper and the counter datapath.

## Interface
- BITS, 32, counter width (also width of load value and counter readback)
- STEP_W, 16, width of the step-count register and remaining-step counter

- clk  input  1  single clock for all state
- reset_n  input  1  asynchronous, active-low reset
- wbs_cyc_i, wbs_stb_i, wbs_we_i  input  1 each  Wishbone cycle, strobe and write enable
- wbs_sel_i  input  4  byte write strobes
- wbs_adr_i  input  32  address; only bits [3:2] are decoded
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  single-cycle acknowledge
- wbs_dat_o  output  32  read data
- la_start  input  1  LA start request, sampled every cycle
- la_steps  input  STEP_W  step count used with la_start
- la_grant  output  1  one-cycle pulse when la_start is accepted
- cnt_value  input  BITS  current counter state
- cnt_en  output  1  counter advances one step per cycle while high
- cnt_clr  output  1  one-cycle synchronous clear to the counter
- cnt_load  output  1  one-cycle load strobe
- cnt_load_val  output  BITS  value loaded when cnt_load is high
- irq_done  output  1  level interrupt, equal to done AND irq_en

## Operation
- Registers (adr[3:2]):
  - 0 CTRL. Write bit0 = start, bit1 = stop, bit2 = clear (self-clearing commands). Bit3 = irq_en (stored). Reads return {28'b0, irq_en, 3'b0}.
  - 1 STEPS. R/W, bits [STEP_W-1:0]; upper bits read 0.
  - 2 STATUS. Bit0 = busy (RO). Bit1 = done (sticky; write 1 to clear). Bit2 = owner (0 = WB, 1 = LA; owner of the last accepted run). Bits [31:16] = remaining (RO).
  - 3 VALUE. Reads return cnt_value. A write requests a load of wbs_dat_i.
- Byte strobes apply to stored fields. A command bit acts only if its byte lane is selected.
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN: on an accepted start with steps ≠ 0. remaining is set to the step count.
  - IDLE to DONE: on an accepted start with steps = 0. cnt_en is never asserted.
  - RUN: cnt_en = 1 and remaining decrements each cycle. When remaining reaches 1 in RUN, the next state is DONE.
  - DONE lasts one cycle: sets done, then the FSM returns to IDLE.
  - Stop while in RUN: the FSM goes to IDLE next cycle. cnt_en drops, done is not set, and remaining holds its value.
- Arbitration (start is only accepted in IDLE):
  - A Wishbone start and la_start in the same cycle: Wishbone wins. la_start is dropped and la_grant stays 0.
  - la_start accepted: la_grant pulses in that cycle, la_steps is used, and owner is set to 1.
  - Wishbone start accepted: STEPS is used and owner is set to 0.
  - Start requests in RUN or DONE are ignored, and no grant is issued.
- Clear and load are accepted only when busy = 0; otherwise they are ignored.
  - Clear: cnt_clr pulses for one cycle.
  - Load: cnt_load pulses for one cycle with cnt_load_val = wbs_dat_i[BITS-1:0]. cnt_load_val holds its value afterwards.
- busy = 1 in RUN and DONE.
- done set and a W1C write to done in the same cycle: set wins.

## Timing
- Reset (asynchronous, reset_n low):
  - State = IDLE; STEPS = 0; remaining = 0; done = 0; irq_en = 0; owner = 0.
  - All outputs are 0: wbs_ack_o, wbs_dat_o, cnt_en, cnt_clr, cnt_load, cnt_load_val, la_grant, irq_done.
- Reset mid-run aborts immediately. There is no residual cnt_en pulse after reset_n rises.
- Wishbone handshake:
  - A request is valid when cyc & stb & !ack.
  - wbs_ack_o is asserted on the clock edge after valid, for exactly one cycle.
  - The write takes effect on that same edge. Read data is registered on that edge and valid while ack is high.
  - Back-to-back transfers therefore complete at most every 2 cycles.
- Start issued at edge E (the ack edge, or the la_start sample edge): cnt_en is high from E for exactly N cycles. done and irq_done rise at edge E+N+1.
- Command-to-pulse latency: cnt_clr and cnt_load are high for the cycle following the accepting edge (same as ack).
- irq_done falls one cycle after the W1C write to done, or after irq_en is cleared.

## Test plan
- Reset values: reset_n low for 3 cycles mid-transaction. All outputs are 0, and reads return STEPS = 0 and STATUS = 0.
- WB run: STEPS = 5, irq_en = 1, write CTRL = 0x9. cnt_en is high for exactly 5 cycles and the counter advances 5 steps. STATUS reads 0x2 and irq_done = 1. Writing STATUS = 0x2 drops irq_done.
- Zero steps and stop:
  - STEPS = 0 with start: done sets with cnt_en never high.
  - STEPS = 100, stop after 10 cycles: cnt_en low, done = 0, remaining = 90.
- Arbitration:
  - WB start and la_start in the same cycle: WB steps used, la_grant = 0, owner = 0.
  - la_start with la_steps = 3 alone: la_grant pulse, cnt_en for 3 cycles, owner = 1.
  - la_start during RUN: ignored.
- Load/clear: in IDLE, write VALUE = 0x0000FFFF, giving one cnt_load pulse and reading back 0x0000FFFF. Clear gives one cnt_clr pulse and VALUE reads 0. Both are ignored while busy.
- Async reset during RUN: cnt_en drops at reset assertion, and the FSM resumes in IDLE after release.
